// File: rtl/diag_collector.sv
// diag_collector: receiving end of the skewed anti-diagonal wavefront stream
// of the 4x4 systolic array. Seven diagonal beats on lanes d1..d4 are
// de-skewed back into a 4x4 matrix of IEEE-754 single words. Each beat either
// overwrites its target words or is added onto them through four fpadd units.
// The finished matrix is offered downstream with a valid/ready handshake.
//
// Handshake: a beat moves when in_valid && in_ready; the matrix is taken when
// out_valid && out_ready. in_ready and out_valid are flops that follow the
// FSM state, so neither has a combinational path from any input. While
// out_valid is high and out_ready is low, mat and count hold.

// fpadd: combinational single-precision adder, round-to-nearest-even,
// with subnormal inputs/outputs, infinities and a quiet-NaN result.
module fpadd (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    logic        a_big;
    logic        sl, ss;
    logic [7:0]  exl, exs;
    logic [22:0] frl, frs;
    logic [26:0] ml, ms, msh;
    logic [27:0] s;
    logic [24:0] m25;
    logic [23:0] mr;
    logic        rnd;
    logic        sticky;
    logic        a_nan, b_nan, a_inf, b_inf;
    int          el, es, sh, e;

    // Align, add or subtract magnitudes, normalise, round, then pack.
    always_comb begin
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);

        // Larger magnitude becomes the "l" operand so subtraction never borrows.
        a_big  = (a[30:0] >= b[30:0]);
        sl     = a_big ? a[31]    : b[31];
        exl    = a_big ? a[30:23] : b[30:23];
        frl    = a_big ? a[22:0]  : b[22:0];
        ss     = a_big ? b[31]    : a[31];
        exs    = a_big ? b[30:23] : a[30:23];
        frs    = a_big ? b[22:0]  : a[22:0];

        // Subnormals use exponent 1 with no hidden bit; 3 guard/round/sticky bits.
        el     = (exl == 8'd0) ? 1 : int'(exl);
        es     = (exs == 8'd0) ? 1 : int'(exs);
        ml     = {(exl != 8'd0), frl, 3'b000};
        ms     = {(exs != 8'd0), frs, 3'b000};

        sh     = el - es;
        sticky = 1'b0;
        if (sh > 26) begin
            msh    = 27'd0;
            sticky = |ms;
        end else begin
            msh    = ms >> sh;
            sticky = |(ms & ((27'd1 << sh) - 27'd1));
        end
        msh[0] = msh[0] | sticky;

        e = el;
        if (sl == ss) begin
            s = {1'b0, ml} + {1'b0, msh};
            if (s[27]) begin
                s = {1'b0, s[27:2], s[1] | s[0]};
                e = e + 1;
            end
        end else begin
            s = {1'b0, ml - msh};
        end

        // Left-normalise after cancellation, stopping at the subnormal floor.
        for (int i = 0; i < 26; i++) begin
            if (!s[26] && (e > 1)) begin
                s = s << 1;
                e = e - 1;
            end
        end

        rnd = s[2] & (s[1] | s[0] | s[3]);
        m25 = {1'b0, s[26:3]} + {24'd0, rnd};
        if (m25[24]) begin
            mr = m25[24:1];
            e  = e + 1;
        end else begin
            mr = m25[23:0];
        end

        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) begin
            y = 32'h7FC00000;
        end else if (a_inf) begin
            y = a;
        end else if (b_inf) begin
            y = b;
        end else if (e >= 255) begin
            y = {sl, 8'hFF, 23'd0};
        end else if (mr == 24'd0) begin
            // Exact cancellation gives +0; only -0 + -0 keeps the sign.
            y = {sl & ss, 31'd0};
        end else begin
            y = {sl, (mr[23] ? 8'(e) : 8'd0), mr[22:0]};
        end
    end

endmodule

module diag_collector (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         acc,
    input  logic [31:0]  d1,
    input  logic [31:0]  d2,
    input  logic [31:0]  d3,
    input  logic [31:0]  d4,
    output logic [2:0]   count,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] mat
);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t      state;
    logic [2:0]  count_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic [31:0] mat_q [16];

    logic [31:0] lane_d   [4];
    logic        lane_en  [4];
    logic [3:0]  lane_idx [4];
    logic [31:0] op_a     [4];
    logic [31:0] sum      [4];
    logic [31:0] wr_val   [4];

    assign lane_d[0] = d1;
    assign lane_d[1] = d2;
    assign lane_d[2] = d3;
    assign lane_d[3] = d4;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign count     = count_q;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_pack
            assign mat[gi*32 +: 32] = mat_q[gi];
        end
    endgenerate

    // Decode which matrix element each lane targets for the current beat.
    // Beats 1..4 fill the upper-left triangle (lane l -> row l), beats 5..7
    // the lower-right one (lane l -> column 5-l); idx is row*4+col, 0-based.
    always_comb begin
        for (int l = 0; l < 4; l++) begin
            lane_en[l]  = 1'b0;
            lane_idx[l] = 4'd0;
            if (count_q <= 3'd4) begin
                if (l < int'(count_q)) begin
                    lane_en[l]  = 1'b1;
                    lane_idx[l] = 4'(l * 4 + (int'(count_q) - 1 - l));
                end
            end else begin
                if (l < 8 - int'(count_q)) begin
                    lane_en[l]  = 1'b1;
                    lane_idx[l] = 4'((int'(count_q) - 4 + l) * 4 + (3 - l));
                end
            end
        end
    end

    // Adder operand mux: current stored word for live lanes, zero otherwise.
    always_comb begin
        for (int l = 0; l < 4; l++) begin
            op_a[l]   = lane_en[l] ? mat_q[lane_idx[l]] : 32'd0;
            wr_val[l] = acc ? sum[l] : lane_d[l];
        end
    end

    generate
        for (gi = 0; gi < 4; gi++) begin : g_add
            fpadd u_fpadd (
                .a (op_a[gi]),
                .b (lane_d[gi]),
                .y (sum[gi])
            );
        end
    endgenerate

    // Collect/present FSM with matrix storage; clear outranks beats and out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= COLLECT;
            count_q     <= 3'd1;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            for (int i = 0; i < 16; i++) mat_q[i] <= 32'd0;
        end else if (clear) begin
            state       <= COLLECT;
            count_q     <= 3'd1;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            for (int i = 0; i < 16; i++) mat_q[i] <= 32'd0;
        end else begin
            case (state)
                COLLECT: begin
                    if (in_valid && in_ready_q) begin
                        for (int l = 0; l < 4; l++) begin
                            if (lane_en[l]) mat_q[lane_idx[l]] <= wr_val[l];
                        end
                        if (count_q == 3'd7) begin
                            state       <= FULL;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            count_q <= count_q + 3'd1;
                        end
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state       <= COLLECT;
                        count_q     <= 3'd1;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= COLLECT;
                    count_q     <= 3'd1;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_diag_collector.sv
// Directed bench for diag_collector: load, bubbles, backpressure,
// accumulate, clear and asynchronous reset.
module tb_diag_collector;

    logic         clk = 1'b0;
    logic         rst;
    logic         clear;
    logic         in_valid;
    logic         in_ready;
    logic         acc;
    logic [31:0]  d1, d2, d3, d4;
    logic [2:0]   count;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] mat;

    int n_cmp = 0;
    int n_err = 0;

    diag_collector dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .acc       (acc),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .d4        (d4),
        .count     (count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mat       (mat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word(input logic [511:0] m, input int i, input int j);
        return m[((i-1)*4+(j-1))*32 +: 32];
    endfunction

    // Element on lane l at beat k lies on anti-diagonal i+j = k+1.
    function automatic logic [31:0] lane_val(input int k, input int l, input int mode,
                                             input logic [31:0] cval, input logic [31:0] filler);
        int i, j;
        i = (k <= 4) ? l : (k - 4 + l);
        j = k + 1 - i;
        if (i < 1 || i > 4 || j < 1 || j > 4) return filler;
        if (mode == 0) return 32'(i * 16 + j);
        return cval;
    endfunction

    function automatic logic [511:0] ij_mat();
        logic [511:0] m;
        m = '0;
        for (int i = 1; i <= 4; i++)
            for (int j = 1; j <= 4; j++)
                m[((i-1)*4+(j-1))*32 +: 32] = 32'(i * 16 + j);
        return m;
    endfunction

    function automatic logic [511:0] const_mat(input logic [31:0] v);
        logic [511:0] m;
        for (int i = 0; i < 16; i++) m[i*32 +: 32] = v;
        return m;
    endfunction

    task automatic set_beat(input int k, input int mode, input logic [31:0] cval,
                            input logic [31:0] filler);
        d1 = lane_val(k, 1, mode, cval, filler);
        d2 = lane_val(k, 2, mode, cval, filler);
        d3 = lane_val(k, 3, mode, cval, filler);
        d4 = lane_val(k, 4, mode, cval, filler);
    endtask

    task automatic run_frame(input logic acc_v, input int mode, input logic [31:0] cval,
                             input bit bubbles, input logic [31:0] filler, input string tag);
        acc = acc_v;
        for (int k = 1; k <= 7; k++) begin
            if (bubbles) begin
                in_valid = 1'b0;
                d1 = $urandom(); d2 = $urandom(); d3 = $urandom(); d4 = $urandom();
                tick();
                check({tag, " bubble count"}, 512'(count), 512'(k));
            end
            set_beat(k, mode, cval, filler);
            in_valid = 1'b1;
            tick();
            check({tag, " beat count"}, 512'(count), 512'((k < 7) ? k + 1 : 7));
        end
        in_valid = 1'b0;
        acc      = 1'b0;
    endtask

    task automatic release_full(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " release count"}, 512'(count), 512'(1));
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; acc = 1'b0; out_ready = 1'b0;
        d1 = '0; d2 = '0; d3 = '0; d4 = '0;
        tick();
        tick();
        check("reset out_valid", 512'(out_valid), 512'(0));
        check("reset in_ready", 512'(in_ready), 512'(1));
        check("reset count", 512'(count), 512'(1));
        check("reset mat", mat, 512'(0));
        rst = 1'b0;
        tick();

        // Load frame with m(i,j) = 0xij
        run_frame(1'b0, 0, 32'd0, 1'b0, 32'hDEADBEEF, "load");
        check("load out_valid", 512'(out_valid), 512'(1));
        check("load in_ready", 512'(in_ready), 512'(0));
        check("load m23", 512'(word(mat, 2, 3)), 512'(32'h23));
        check("load m44", 512'(word(mat, 4, 4)), 512'(32'h44));
        check("load mat", mat, ij_mat());

        // Backpressure: FULL holds while out_ready is low
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            d1 = $urandom(); d2 = $urandom(); d3 = $urandom(); d4 = $urandom();
            tick();
            check("bp mat", mat, ij_mat());
            check("bp count", 512'(count), 512'(7));
            check("bp out_valid", 512'(out_valid), 512'(1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp rel out_valid", 512'(out_valid), 512'(0));
        check("bp rel in_ready", 512'(in_ready), 512'(1));
        check("bp rel count", 512'(count), 512'(1));

        // Clear, then bubbles with DEADBEEF on unused lanes
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear pulse mat", mat, 512'(0));
        run_frame(1'b0, 0, 32'd0, 1'b1, 32'hDEADBEEF, "bubble");
        check("bubble mat", mat, ij_mat());
        check("bubble out_valid", 512'(out_valid), 512'(1));
        release_full("bubble");

        // Accumulate 1.0 frames, then subtract one
        run_frame(1'b0, 1, 32'h3F800000, 1'b0, 32'hDEADBEEF, "ones");
        check("ones mat", mat, const_mat(32'h3F800000));
        release_full("ones");
        run_frame(1'b1, 1, 32'h3F800000, 1'b0, 32'hDEADBEEF, "acc2");
        check("acc2 mat", mat, const_mat(32'h40000000));
        release_full("acc2");
        run_frame(1'b1, 1, 32'h3F800000, 1'b0, 32'hDEADBEEF, "acc3");
        check("acc3 mat", mat, const_mat(32'h40400000));
        release_full("acc3");
        run_frame(1'b1, 1, 32'hBF800000, 1'b0, 32'hDEADBEEF, "accm1");
        check("accm1 mat", mat, const_mat(32'h40000000));
        release_full("accm1");

        // Clear together with accepted beat 4
        for (int k = 1; k <= 3; k++) begin
            set_beat(k, 0, 32'd0, 32'hDEADBEEF);
            in_valid = 1'b1;
            tick();
        end
        set_beat(4, 0, 32'd0, 32'hDEADBEEF);
        in_valid = 1'b1;
        clear    = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clr4 mat", mat, 512'(0));
        check("clr4 count", 512'(count), 512'(1));
        check("clr4 in_ready", 512'(in_ready), 512'(1));
        check("clr4 out_valid", 512'(out_valid), 512'(0));
        run_frame(1'b0, 0, 32'd0, 1'b0, 32'hDEADBEEF, "postclr");
        check("postclr mat", mat, ij_mat());
        release_full("postclr");

        // Asynchronous reset during beat 5
        for (int k = 1; k <= 4; k++) begin
            set_beat(k, 0, 32'd0, 32'hDEADBEEF);
            in_valid = 1'b1;
            tick();
        end
        check("pre-rst count", 512'(count), 512'(5));
        set_beat(5, 0, 32'd0, 32'hDEADBEEF);
        #2;
        rst = 1'b1;
        #1;
        check("arst mat", mat, 512'(0));
        check("arst out_valid", 512'(out_valid), 512'(0));
        check("arst count", 512'(count), 512'(1));
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        run_frame(1'b0, 0, 32'd0, 1'b0, 32'hDEADBEEF, "postrst");
        check("postrst mat", mat, ij_mat());
        check("postrst out_valid", 512'(out_valid), 512'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
